csi_rx_dly_cal: RTL
===================

Name: csi_rx_dly_cal

Overview:
- Per-lane input-delay calibration controller for the CSI-2 RX front end.
- Sweeps the IDELAY tap of every data-lane PHY in parallel and counts sync-sequence detections from the byte aligners at each tap.
- Finds the longest contiguous passing tap window per lane and programs each lane to the centre of its window.
- Sits between the clock detector / camera-enable logic and the data PHYs and aligners; replaces the fixed per-lane skew constants with values found at run time.

Parameters:
- NUM_LANE, 2: number of data lanes.
- TAP_W, 5: delay tap width; taps run 0..2^TAP_W-1.
- DEFAULT_TAP, 16: tap driven out of reset and on a failed lane.
- SETTLE_CYC, 32: cycles `align_reset` is held after each tap load.
- DWELL_CYC, 4096: observation cycles per tap.
- MIN_HITS, 4: sync hits needed in one dwell for a tap to pass.

Ports:
- `clock`, in, 1: byte clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: single-cycle calibration request.
- `sync_hit`, in, NUM_LANE: per-lane pulse; byte aligner found a sync sequence.
- `dly_tap`, out, NUM_LANE*TAP_W: tap value per lane.
- `dly_load`, out, 1: one-cycle pulse that loads `dly_tap` into all IDELAYs.
- `align_reset`, out, 1: reset to byte/word aligners while taps settle.
- `busy`, out, 1: calibration in progress.
- `done`, out, 1: level; calibration complete.
- `fail`, out, NUM_LANE: per-lane no-passing-window flag.

Behaviour:
- Reset values:
  - `dly_tap` = DEFAULT_TAP on every lane.
  - `dly_load`, `align_reset`, `busy`, `done`, `fail` = 0.
  - FSM = IDLE.
- FSM states: IDLE, LOAD, SETTLE, DWELL, EVAL, FINAL_LOAD, FINAL_SETTLE, DONE.
- IDLE / DONE:
  - `start`=1 → LOAD with sweep tap t=0.
  - On that transition: clear `done`, `fail` and all window trackers; set `busy`=1.
- LOAD (1 cycle):
  - Drive `dly_tap`=t on all lanes, `dly_load`=1, `align_reset`=1.
  - Next state SETTLE.
- SETTLE:
  - Hold `align_reset`=1 for SETTLE_CYC cycles.
  - Then go to DWELL and clear the hit counters.
- DWELL:
  - `align_reset`=0 for DWELL_CYC cycles.
  - Per-lane hit counter increments on `sync_hit`, saturating at MIN_HITS.
  - `sync_hit` is ignored in every other state.
- EVAL (1 cycle):
  - Lane passes iff hits == MIN_HITS. Window update below.
  - If t == 2^TAP_W-1 → FINAL_LOAD; else t=t+1 → LOAD.
- Window tracker, per lane (cur_start, cur_len, best_start, best_len):
  - On pass: if cur_len==0 then cur_start=t; cur_len=cur_len+1.
  - If the new cur_len > best_len (strictly greater), copy cur into best. The earliest window wins ties.
  - On fail: cur_len=0.
  - Length counters are TAP_W+1 bits wide, so a full-range pass of 2^TAP_W does not wrap.
- FINAL_LOAD (1 cycle):
  - Per lane: if best_len>0, tap = best_start + (best_len>>1) (floor); else tap = DEFAULT_TAP and `fail[i]`=1.
  - `dly_load`=1, `align_reset`=1.
- FINAL_SETTLE:
  - Hold `align_reset`=1 for SETTLE_CYC cycles.
  - Then DONE: `busy`=0, `done`=1; hold until the next `start`.
- Boundary rules:
  - `start` while `busy` is ignored.
  - A window touching the last tap is closed at sweep end; no wrap to tap 0.
  - Asynchronous `reset` mid-sweep returns every output to its reset value immediately.
- Latency from `start` to `done`: 2^TAP_W*(SETTLE_CYC+DWELL_CYC+2) + SETTLE_CYC + 2 cycles.

Optional Feature:
- Macro `CSI_RX_DLY_CAL_STATS_EN`.
- Defined:
  - Adds output `win_len` (NUM_LANE*(TAP_W+1)), holding each lane's best_len, valid while `done`=1.
  - Adds output `cal_count` (8 bits), incremented at each DONE entry and saturating at 255.
  - Both reset to 0.
- Undefined: neither port exists and no related logic is built.

Decomposition:
- top_pkg holds:
  - `tap_t` (logic[TAP_W-1:0]) and `lane_tap_t` (tap_t[NUM_LANE-1:0]).
  - `cal_state_t` enum.
  - DEFAULT_TAP, SETTLE_CYC, DWELL_CYC, MIN_HITS.
- Sub-module `csi_rx_dly_win`: one instance per lane.
  - Contains the hit counter, pass decision, window tracker and centre computation.
- The FSM and the settle/dwell counter stay in the top module.

Test Plan:
- Lane0 hits only on taps 10..17, lane1 only on 20..27 → final `dly_tap` = {24,14}, `fail`=0, `done`=1, one `dly_load` per tap plus one final load.
- Lane0 passes taps 2..5 and 20..23 (tie) → tap 4.
- Lane1 passes 28..31 → tap 30, with no wrap.
- No hits on lane1 → `fail[1]`=1, lane1 tap=16, lane0 still calibrated.
- Exactly MIN_HITS-1 = 3 hits per dwell on all taps → all lanes fail.
- Hits asserted during SETTLE only → not counted, lane fails.
- `start` pulsed mid-DWELL → ignored, sweep continues unchanged.
- `reset` asserted mid-DWELL → `dly_tap`=16, `busy`=0, `done`=0, `align_reset`=0 immediately.
- A new `start` afterwards completes a full sweep normally.
- With `CSI_RX_DLY_CAL_STATS_EN` and lane0 window 10..17 → `win_len[0]`=8; `cal_count` reads 2 after two back-to-back calibrations.

Source files
------------

// File: rtl/csi_rx_dly_cal_pkg.sv
// Shared types and constants for the CSI-2 RX per-lane delay calibration.
// Optional build macro: CSI_RX_DLY_CAL_STATS_EN (adds win_len / cal_count outputs).
package csi_rx_dly_cal_pkg;

   localparam int unsigned NUM_LANE    = 2;
   localparam int unsigned TAP_W       = 5;
   localparam int unsigned DEFAULT_TAP = 16;
   localparam int unsigned SETTLE_CYC  = 32;
   localparam int unsigned DWELL_CYC   = 4096;
   localparam int unsigned MIN_HITS    = 4;

   // One extra bit so a window covering every tap does not wrap to zero.
   localparam int unsigned LEN_W   = TAP_W + 1;
   localparam int unsigned NUM_TAP = 1 << TAP_W;

   typedef logic [TAP_W-1:0]    tap_t;
   typedef tap_t [NUM_LANE-1:0] lane_tap_t;
   typedef logic [LEN_W-1:0]    len_t;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSettle,
      StDwell,
      StEval,
      StFinalLoad,
      StFinalSettle,
      StDone
   } cal_state_t;

   // Centre of a window, rounding down.
   function automatic tap_t win_centre(input tap_t start, input len_t len);
      return start + tap_t'(len >> 1);
   endfunction

endpackage

// File: rtl/csi_rx_dly_cal_win.sv
// Per-lane sync-hit counter, pass decision, longest-window tracker and centre tap.
// Optional build macro: CSI_RX_DLY_CAL_STATS_EN (best_len is exported for statistics).
module csi_rx_dly_win
   import csi_rx_dly_cal_pkg::*;
#(
   parameter int unsigned MIN_HITS = csi_rx_dly_cal_pkg::MIN_HITS
) (
   input  logic clock,
   input  logic reset,
   input  logic win_clr,
   input  logic hit_clr,
   input  logic hit_en,
   input  logic sync_hit,
   input  logic eval,
   input  tap_t tap,
   output tap_t ctr_tap,
   output logic win_ok,
   output len_t best_len
);

   localparam int unsigned HIT_W = $clog2(MIN_HITS + 1);

   logic [HIT_W-1:0] hits_q;
   tap_t             cur_start_q, cur_start_d, best_start_q, best_start_d;
   len_t             cur_len_q, cur_len_d, best_len_q, best_len_d;
   logic             pass;

   assign pass = (hits_q == HIT_W'(MIN_HITS));

   // Hit counter, only counts while dwelling and saturates at MIN_HITS.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hits_q <= '0;
      end else if (hit_clr || win_clr) begin
         hits_q <= '0;
      end else if (hit_en && sync_hit && !pass) begin
         hits_q <= hits_q + 1'b1;
      end
   end

   // Window tracker next state; strict compare keeps the earliest of equal windows.
   always_comb begin
      cur_start_d  = cur_start_q;
      cur_len_d    = cur_len_q;
      best_start_d = best_start_q;
      best_len_d   = best_len_q;
      if (win_clr) begin
         cur_start_d  = '0;
         cur_len_d    = '0;
         best_start_d = '0;
         best_len_d   = '0;
      end else if (eval) begin
         if (pass) begin
            if (cur_len_q == '0) begin
               cur_start_d = tap;
            end
            cur_len_d = cur_len_q + 1'b1;
            if (cur_len_d > best_len_q) begin
               best_start_d = cur_start_d;
               best_len_d   = cur_len_d;
            end
         end else begin
            cur_len_d = '0;
         end
      end
   end

   // Window tracker registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur_start_q  <= '0;
         cur_len_q    <= '0;
         best_start_q <= '0;
         best_len_q   <= '0;
      end else begin
         cur_start_q  <= cur_start_d;
         cur_len_q    <= cur_len_d;
         best_start_q <= best_start_d;
         best_len_q   <= best_len_d;
      end
   end

   // Derived from next-state values so the last tap's evaluation is included.
   assign ctr_tap  = win_centre(best_start_d, best_len_d);
   assign win_ok   = (best_len_d != '0);
   assign best_len = best_len_q;

endmodule

// File: rtl/csi_rx_dly_cal.sv
// CSI-2 RX input-delay calibration: sweeps all IDELAY taps, centres each lane in
// its longest passing window.
// Optional build macro: CSI_RX_DLY_CAL_STATS_EN (adds win_len and cal_count outputs).
module csi_rx_dly_cal
   import csi_rx_dly_cal_pkg::*;
#(
   parameter int unsigned DEFAULT_TAP = csi_rx_dly_cal_pkg::DEFAULT_TAP,
   parameter int unsigned SETTLE_CYC  = csi_rx_dly_cal_pkg::SETTLE_CYC,
   parameter int unsigned DWELL_CYC   = csi_rx_dly_cal_pkg::DWELL_CYC,
   parameter int unsigned MIN_HITS    = csi_rx_dly_cal_pkg::MIN_HITS
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic [NUM_LANE-1:0]       sync_hit,
   output logic [NUM_LANE*TAP_W-1:0] dly_tap,
   output logic                      dly_load,
   output logic                      align_reset,
   output logic                      busy,
   output logic                      done,
`ifdef CSI_RX_DLY_CAL_STATS_EN
   output logic [NUM_LANE*LEN_W-1:0] win_len,
   output logic [7:0]                cal_count,
`endif
   output logic [NUM_LANE-1:0]       fail
);

   localparam tap_t DEF_TAP  = tap_t'(DEFAULT_TAP);
   localparam tap_t LAST_TAP = tap_t'(NUM_TAP - 1);

   cal_state_t                state;
   tap_t                      sweep;
   lane_tap_t                 tap_q;
   logic [15:0]               cnt;
   logic                      win_clr, hit_clr, hit_en, eval;
   logic                      settle_end;
   lane_tap_t                 ctr_tap;
   logic [NUM_LANE-1:0]       win_ok;
   len_t [NUM_LANE-1:0]       best_len;

   assign win_clr    = start && (state == StIdle || state == StDone);
   assign settle_end = (cnt == 16'(SETTLE_CYC - 1));
   assign hit_clr    = (state == StSettle) && settle_end;
   assign hit_en     = (state == StDwell);
   assign eval       = (state == StEval);
   assign dly_tap    = tap_q;

   for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
      csi_rx_dly_win #(
         .MIN_HITS (MIN_HITS)
      ) u_win (
         .clock    (clock),
         .reset    (reset),
         .win_clr  (win_clr),
         .hit_clr  (hit_clr),
         .hit_en   (hit_en),
         .sync_hit (sync_hit[i]),
         .eval     (eval),
         .tap      (sweep),
         .ctr_tap  (ctr_tap[i]),
         .win_ok   (win_ok[i]),
         .best_len (best_len[i])
      );
   end

   // Sweep FSM with registered outputs and shared settle/dwell counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= StIdle;
         sweep       <= '0;
         cnt         <= '0;
         tap_q       <= {NUM_LANE{DEF_TAP}};
         dly_load    <= 1'b0;
         align_reset <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         fail        <= '0;
      end else begin
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  state       <= StLoad;
                  sweep       <= '0;
                  tap_q       <= '0;
                  dly_load    <= 1'b1;
                  align_reset <= 1'b1;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  fail        <= '0;
               end
            end
            StLoad: begin
               dly_load <= 1'b0;
               cnt      <= '0;
               state    <= StSettle;
            end
            StSettle: begin
               if (settle_end) begin
                  cnt         <= '0;
                  align_reset <= 1'b0;
                  state       <= StDwell;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StDwell: begin
               if (cnt == 16'(DWELL_CYC - 1)) begin
                  cnt   <= '0;
                  state <= StEval;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StEval: begin
               dly_load    <= 1'b1;
               align_reset <= 1'b1;
               if (sweep == LAST_TAP) begin
                  for (int i = 0; i < NUM_LANE; i++) begin
                     tap_q[i] <= win_ok[i] ? ctr_tap[i] : DEF_TAP;
                  end
                  fail  <= ~win_ok;
                  state <= StFinalLoad;
               end else begin
                  sweep <= sweep + 1'b1;
                  tap_q <= {NUM_LANE{tap_t'(sweep + 1'b1)}};
                  state <= StLoad;
               end
            end
            StFinalLoad: begin
               dly_load <= 1'b0;
               cnt      <= '0;
               state    <= StFinalSettle;
            end
            StFinalSettle: begin
               if (settle_end) begin
                  cnt         <= '0;
                  align_reset <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= StDone;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

`ifdef CSI_RX_DLY_CAL_STATS_EN
   assign win_len = best_len;

   // Completed-calibration counter, saturating.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cal_count <= '0;
      end else if (state == StFinalSettle && settle_end && cal_count != 8'hff) begin
         cal_count <= cal_count + 1'b1;
      end
   end
`endif

endmodule
